rf_read_arbiter: RTL and testbench
==================================

# rf_read_arbiter

Round-robin arbiter that shares the register file's single 32-entry read port among R requesters. Each cycle it picks at most one pending requester, drives the winner's 5-bit register index onto the read-mux select, captures the mux output one cycle later, and returns it to the winner with a valid strobe. It sits between the decode/execute requesters and the register-file read mux, and is pipelined to issue one grant per cycle.

## Interface

- `N`, default 32: data width of a register and of the read-mux output.
- `R`, default 4: number of requesters, 2..8.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  R  per-requester read request; held until granted.
- `addr`  in  5*R  per-requester register index; requester i uses bits [5i+4:5i]; stable while `req[i]` is high.
- `rf_stall`  in  1  when high, no new grant is issued; write-port priority.
- `gnt`  out  R  one-hot grant pulse; registered.
- `rf_sel`  out  5  select to the 32-way read mux; registered.
- `rf_data`  in  N  read-mux output for the current `rf_sel`.
- `rvalid`  out  R  one-hot pulse; `rdata` belongs to this requester.
- `rdata`  out  N  captured read data; registered.

## Operation

- State: round-robin pointer `last` (index of the most recent winner, reset R-1); stage-1 registers `gnt`, `rf_sel`; stage-2 registers `rvalid`, `rdata`, and the forced-zero flag (see Configuration).
- Eligible set at each edge: `req[i]` high AND `gnt[i]` currently low. A requester granted this cycle is excluded at this edge, which blocks a double grant for the same request.
- Arbitration: scan indices `last+1, last+2, …` modulo R. The first eligible index wins. Ties never occur.
- On a win with `rf_stall` low:
  - `gnt[w]` is set to 1 and all other grant bits to 0.
  - `rf_sel` takes `addr[w]`.
  - `last` takes w.
- No eligible requester, or `rf_stall` high:
  - `gnt` takes 0; `last` is unchanged.
  - `rf_sel` holds its previous value.
- Stage 2 at each edge:
  - `rvalid` takes the previous `gnt`.
  - If the previous `gnt` is nonzero, `rdata` takes `rf_data`; otherwise `rdata` holds.
- Requester contract:
  - Drop `req[i]`, or present a new `addr`, in the cycle `gnt[i]` is seen high.
  - A `req[i]` still high after that cycle is treated as a new request.
- Fairness: with all R requesting continuously, each requester is granted once in every R grant cycles.
- Single-requester throughput: one grant every 2 cycles, because of the exclusion rule.
- `rf_stall` has no effect on a grant already issued; that read completes normally in stage 2.

## Timing

- Reset (asynchronous, `rst_n` low): `gnt`=0, `rvalid`=0, `rf_sel`=0, `rdata`=0, `last`=R-1, so requester 0 has first priority.
- Reset asserted mid-operation: in-flight grants and reads are discarded; no `rvalid` appears after reset release for a request made before reset.
- Latency: `req` sampled high at edge t gives `gnt` high in cycle t+1 and `rvalid`/`rdata` in cycle t+2.
- `rf_data` must settle combinationally from `rf_sel` within one cycle. The arbiter adds no combinational path from `req`/`addr` to any output.
- Back-to-back: different requesters may win on consecutive edges, giving one `rvalid` per cycle.

## Configuration

- `RF_ZERO_REG_EN` defined: a grant whose index is 0 sets the stage-2 forced-zero flag, and `rdata` is driven to 0 with `rvalid` regardless of `rf_data`. This gives hardwired register x0.
- `RF_ZERO_REG_EN` undefined: index 0 is an ordinary register and `rdata` = `rf_data`.

## Test plan

- Reset: hold `rst_n`=0 with `req`=4'b1111 -> `gnt`=0, `rvalid`=0, `rf_sel`=0, `rdata`=0. Release -> first grant goes to requester 0.
- Single read: `req[2]`=1, `addr[2]`=7, `rf_data`=32'hDEADBEEF while `rf_sel`=7 -> `gnt`=4'b0100 and `rf_sel`=7 at t+1; `rvalid`=4'b0100 and `rdata`=32'hDEADBEEF at t+2.
- Round robin: all four requesting continuously, each re-raising `req` after its grant -> grant order 0,1,2,3,0,…; one `rvalid` per cycle after the pipeline fills.
- Stall: `rf_stall`=1 for 3 cycles with `req[1]` high -> no `gnt` during the stall; `gnt[1]` the cycle after `rf_stall` falls; `last` unchanged during the stall.
- Zero register: `addr[0]`=0, `rf_data`=32'h12345678 -> `rdata`=0 with `RF_ZERO_REG_EN` defined; `rdata`=32'h12345678 without it.
- Reset mid-flight: assert `rst_n`=0 in the cycle `gnt[3]` is high -> no `rvalid[3]` after reset release; `last` returns to R-1.

Source files
------------

// File: rtl/rf_read_arbiter.sv
// rf_read_arbiter: round-robin arbiter for the register file's single read port.
// Stage 1 issues one one-hot grant per cycle and drives the read-mux select.
// Stage 2 captures the mux output and returns it with a one-hot valid strobe.
// Optional feature macro: RF_ZERO_REG_EN (register index 0 reads as zero).
module rf_read_arbiter #(
  parameter int N = 32,
  parameter int R = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [R-1:0]   req,
  input  logic [5*R-1:0] addr,
  input  logic           rf_stall,
  output logic [R-1:0]   gnt,
  output logic [4:0]     rf_sel,
  input  logic [N-1:0]   rf_data,
  output logic [R-1:0]   rvalid,
  output logic [N-1:0]   rdata
);

  localparam int LW = (R > 1) ? $clog2(R) : 1;
  localparam logic [LW-1:0] LAST_RST = LW'(R - 1);

  logic [LW-1:0] last;
  logic [R-1:0]  eligible;
  logic          win_found;
  logic [LW-1:0] win_idx;
  logic [LW-1:0] scan_idx;
  logic [R-1:0]  win_onehot;
  logic [4:0]    win_addr;
  logic [N-1:0]  rdata_q;

  // Pick the first eligible requester after the previous winner; a requester
  // granted this cycle is masked so one request cannot be granted twice.
  always_comb begin
    eligible   = req & ~gnt;
    win_found  = 1'b0;
    win_idx    = last;
    scan_idx   = last;
    win_onehot = '0;
    win_addr   = rf_sel;
    for (int k = 1; k <= R; k++) begin
      scan_idx = LW'((int'(last) + k) % R);
      if (!win_found && eligible[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
    if (win_found) begin
      win_onehot[win_idx] = 1'b1;
      win_addr            = addr[5*win_idx +: 5];
    end
  end

  // Stage 1: grant pulse, mux select and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt    <= '0;
      rf_sel <= '0;
      last   <= LAST_RST;
    end else if (win_found && !rf_stall) begin
      gnt    <= win_onehot;
      rf_sel <= win_addr;
      last   <= win_idx;
    end else begin
      gnt    <= '0;
    end
  end

  // Stage 2: return the mux output to the requester granted last cycle;
  // data holds when nothing was granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid  <= '0;
      rdata_q <= '0;
    end else begin
      rvalid <= gnt;
      if (|gnt) begin
        rdata_q <= rf_data;
      end
    end
  end

`ifdef RF_ZERO_REG_EN
  logic zero_flag;

  // Remember whether the captured read targeted x0 so it can be forced to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_flag <= 1'b0;
    end else if (|gnt) begin
      zero_flag <= (rf_sel == 5'd0);
    end
  end

  assign rdata = zero_flag ? '0 : rdata_q;
`else
  assign rdata = rdata_q;
`endif

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Testbench for rf_read_arbiter: directed scenarios plus randomized traffic,
// each cycle checked against a rule-level reference model.
module tb_rf_read_arbiter;

  localparam int N = 32;
  localparam int R = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [R-1:0]   req = '0;
  logic [5*R-1:0] addr = '0;
  logic           rf_stall = 1'b0;
  logic [R-1:0]   gnt;
  logic [4:0]     rf_sel;
  logic [N-1:0]   rf_data;
  logic [R-1:0]   rvalid;
  logic [N-1:0]   rdata;

  logic [N-1:0]   regs [32];

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [R-1:0] m_gnt;
  logic [R-1:0] m_rvalid;
  logic [4:0]   m_sel;
  logic [N-1:0] m_rdata;
  int           m_last;

  always #5 clk = ~clk;

  assign rf_data = regs[rf_sel];

  rf_read_arbiter #(.N(N), .R(R)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .addr     (addr),
    .rf_stall (rf_stall),
    .gnt      (gnt),
    .rf_sel   (rf_sel),
    .rf_data  (rf_data),
    .rvalid   (rvalid),
    .rdata    (rdata)
  );

  function automatic logic [N-1:0] exp_data(input logic [4:0] sel);
`ifdef RF_ZERO_REG_EN
    if (sel == 5'd0) return '0;
`endif
    return regs[sel];
  endfunction

  task automatic model_reset();
    m_gnt    = '0;
    m_rvalid = '0;
    m_sel    = '0;
    m_rdata  = '0;
    m_last   = R - 1;
  endtask

  // Applies the arbitration rules for the coming clock edge to the model.
  task automatic model_step();
    logic [R-1:0] elig;
    int w;
    elig = req & ~m_gnt;
    w = -1;
    if (!rf_stall) begin
      for (int k = 1; k <= R; k++) begin
        int idx;
        idx = (m_last + k) % R;
        if (w < 0 && elig[idx]) w = idx;
      end
    end
    m_rvalid = m_gnt;
    if (m_gnt != '0) m_rdata = exp_data(m_sel);
    m_gnt = '0;
    if (w >= 0) begin
      m_gnt[w] = 1'b1;
      m_sel    = addr[5*w +: 5];
      m_last   = w;
    end
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    total++;
    if ({gnt, rf_sel, rvalid, rdata} !== {m_gnt, m_sel, m_rvalid, m_rdata}) begin
      bad++;
      $display("FAIL %s t=%0t gnt got %b exp %b, rf_sel got %0d exp %0d, rvalid got %b exp %b, rdata got %h exp %h",
               tag, $time, gnt, m_gnt, rf_sel, m_sel, rvalid, m_rvalid, rdata, m_rdata);
    end
  endtask

  task automatic idle(input int n);
    req = '0;
    rf_stall = 1'b0;
    for (int i = 0; i < n; i++) cycle("idle");
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < R; i++) addr[5*i +: 5] = 5'(i + 3);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
    total++;
    if (rvalid !== 4'b0000) begin bad++; $display("FAIL reset_rvalid got %b exp 0000", rvalid); end
    total++;
    if (rf_sel !== 5'd0) begin bad++; $display("FAIL reset_rf_sel got %0d exp 0", rf_sel); end
    total++;
    if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle("reset_first");
    total++;
    if (gnt !== 4'b0001) begin bad++; $display("FAIL reset_first_winner got %b exp 0001", gnt); end
    idle(3);
  endtask

  task automatic test_single_read();
    regs[7] = 32'hDEADBEEF;
    req = 4'b0100;
    addr[10 +: 5] = 5'd7;
    cycle("single_t1");
    total++;
    if (gnt !== 4'b0100 || rf_sel !== 5'd7) begin
      bad++; $display("FAIL single_grant got gnt=%b sel=%0d exp gnt=0100 sel=7", gnt, rf_sel);
    end
    req = '0;
    cycle("single_t2");
    total++;
    if (rvalid !== 4'b0100 || rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL single_data got rvalid=%b rdata=%h exp rvalid=0100 rdata=deadbeef", rvalid, rdata);
    end
    idle(2);
  endtask

  task automatic test_round_robin();
    int first;
    req = 4'b1111;
    for (int i = 0; i < R; i++) addr[5*i +: 5] = 5'(10 + i);
    cycle("rr_start");
    first = m_last;
    for (int k = 1; k <= 2 * R; k++) begin
      logic [R-1:0] e;
      cycle("rr");
      e = '0;
      e[(first + k) % R] = 1'b1;
      total++;
      if (gnt !== e) begin bad++; $display("FAIL rr_order got %b exp %b", gnt, e); end
      total++;
      if ($countones(rvalid) != 1) begin bad++; $display("FAIL rr_rvalid_rate got %b exp one-hot", rvalid); end
    end
    idle(3);
  endtask

  task automatic test_stall();
    int saved;
    saved = m_last;
    req = 4'b0010;
    addr[5 +: 5] = 5'd21;
    rf_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle("stall");
      total++;
      if (gnt !== 4'b0000 || dut.last !== 2'(saved)) begin
        bad++; $display("FAIL stall_hold got gnt=%b last=%0d exp gnt=0000 last=%0d", gnt, dut.last, saved);
      end
    end
    rf_stall = 1'b0;
    cycle("stall_release");
    total++;
    if (gnt !== 4'b0010) begin bad++; $display("FAIL stall_release got %b exp 0010", gnt); end
    idle(3);
  endtask

  task automatic test_zero_reg();
    logic [N-1:0] e;
    regs[0] = 32'h12345678;
`ifdef RF_ZERO_REG_EN
    e = '0;
`else
    e = 32'h12345678;
`endif
    req = 4'b0001;
    addr[0 +: 5] = 5'd0;
    cycle("zero_t1");
    req = '0;
    cycle("zero_t2");
    total++;
    if (rvalid !== 4'b0001 || rdata !== e) begin
      bad++; $display("FAIL zero_reg got rvalid=%b rdata=%h exp rvalid=0001 rdata=%h", rvalid, rdata, e);
    end
    idle(2);
  endtask

  task automatic test_reset_midflight();
    req = 4'b1000;
    addr[15 +: 5] = 5'd9;
    cycle("mid_grant");
    total++;
    if (gnt !== 4'b1000) begin bad++; $display("FAIL mid_grant got %b exp 1000", gnt); end
    rst_n = 1'b0;
    req = '0;
    #1;
    total++;
    if (gnt !== 4'b0000 || rvalid !== 4'b0000) begin
      bad++; $display("FAIL mid_async got gnt=%b rvalid=%b exp 0000/0000", gnt, rvalid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      cycle("mid_after");
      total++;
      if (rvalid[3] !== 1'b0 || dut.last !== 2'(R - 1)) begin
        bad++; $display("FAIL mid_after got rvalid=%b last=%0d exp rvalid[3]=0 last=%0d", rvalid, dut.last, R - 1);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rf_stall = ($urandom_range(0, 4) == 0);
      cycle("random");
      for (int i = 0; i < R; i++) begin
        if (m_gnt[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else addr[5*i +: 5] = 5'($urandom_range(0, 31));
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          addr[5*i +: 5] = 5'($urandom_range(0, 31));
        end
      end
    end
    idle(3);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    model_reset();
    #2;
    test_reset();
    test_single_read();
    test_round_robin();
    test_stall();
    test_zero_reg();
    test_random();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
